// File: rtl/tl_rx_vc_pkg.sv
// rtl/tl_rx_vc_pkg.sv - shared FSM encodings, channel indices and pointer widths for the RX VC buffer controller
package tl_rx_vc_pkg;

   // ST_HDR is the sop cycle seen from IDLE; it is never held in the state register
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_HDR  = 2'b01;
   localparam logic [1:0] ST_DATA = 2'b10;
   localparam logic [1:0] ST_CHK  = 2'b11;

   localparam int CH_P   = 0;
   localparam int CH_NP  = 1;
   localparam int CH_CPL = 2;

   localparam int HDR_ADDR_W_DEF  = 7;
   localparam int DATA_ADDR_W_DEF = 10;
   localparam int HDR_PTR_W_DEF   = HDR_ADDR_W_DEF + 1;
   localparam int DATA_PTR_W_DEF  = DATA_ADDR_W_DEF + 1;

   function automatic int ptr_w(input int addr_w);
      return addr_w + 1;
   endfunction

endpackage

// File: rtl/tl_rx_vc_buffer_ctrl_mc_ring_ptr.sv
// rtl/tl_rx_vc_buffer_ctrl_mc_ring_ptr.sv - read / committed / speculative ring pointer triplet with flags
module tl_rx_vc_ring_ptr #(
   parameter int ADDR_W = 7,
   parameter int INC_W  = 3
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              wr_en,
   input  logic [INC_W-1:0]  wr_cnt,
   input  logic              commit,
   input  logic              discard,
   input  logic              rd_en,
   input  logic [INC_W-1:0]  rd_cnt,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              empty,
   output logic              full,
   output logic [ADDR_W:0]   free,
   output logic [INC_W-1:0]  pop_cnt
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0] rd_ptr, cmt_ptr, spec_ptr;
   logic [ADDR_W:0] occ, used, rd_cnt_ext, wr_cnt_ext, pop_ext;

   assign occ        = cmt_ptr - rd_ptr;
   assign used       = spec_ptr - rd_ptr;
   assign free       = DEPTH - used;
   assign rd_cnt_ext = (ADDR_W+1)'(rd_cnt);
   assign wr_cnt_ext = (ADDR_W+1)'(wr_cnt);

   // pops are clipped to what has been committed, so an empty ring never underflows
   assign pop_cnt = !rd_en ? '0 : ((rd_cnt_ext <= occ) ? rd_cnt : occ[INC_W-1:0]);
   assign pop_ext = (ADDR_W+1)'(pop_cnt);

   assign empty   = (rd_ptr == cmt_ptr);
   assign full    = (spec_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                    (spec_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
   assign wr_addr = spec_ptr[ADDR_W-1:0];
   assign rd_addr = rd_ptr[ADDR_W-1:0];

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_ptr   <= '0;
         cmt_ptr  <= '0;
         spec_ptr <= '0;
      end else begin
         rd_ptr <= rd_ptr + pop_ext;
         if (discard)
            spec_ptr <= cmt_ptr;
         else if (wr_en)
            spec_ptr <= spec_ptr + wr_cnt_ext;
         if (commit)
            cmt_ptr <= spec_ptr;
      end
   end

endmodule

// File: rtl/tl_rx_vc_buffer_ctrl_mc.sv
// rtl/tl_rx_vc_buffer_ctrl_mc.sv - multi-channel RX VC header/data ring controller with speculative commit/discard
// Optional credit-return outputs are built when TL_RX_VC_CREDIT_RET_EN is defined.
module tl_rx_vc_buffer_ctrl_mc
   import tl_rx_vc_pkg::*;
#(
   parameter int NUM_CH       = 3,
   parameter int HDR_ADDR_W   = 7,
   parameter int DATA_ADDR_W  = 10,
   parameter int DATA_MAX_INC = 4,
   parameter int INC_W        = 3
) (
   input  logic                          i_clk,
   input  logic                          i_n_rst,
   input  logic                          i_w_valid,
   output logic                          o_w_ready,
   input  logic                          i_w_sop,
   input  logic                          i_w_eop,
   input  logic [$clog2(NUM_CH)-1:0]     i_w_ch,
   input  logic [INC_W-1:0]              i_w_data_cnt,
   input  logic                          i_chk_valid,
   input  logic                          i_chk_ok,
   output logic                          o_w_hdr_en,
   output logic                          o_w_data_en,
   output logic [$clog2(NUM_CH)-1:0]     o_w_ch_sel,
   output logic [HDR_ADDR_W-1:0]         o_w_hdr_addr,
   output logic [DATA_ADDR_W-1:0]        o_w_data_addr,
   input  logic [NUM_CH-1:0]             i_r_hdr_inc,
   input  logic [NUM_CH-1:0]             i_r_data_inc,
   input  logic [NUM_CH*INC_W-1:0]       i_r_data_cnt,
   output logic [NUM_CH*HDR_ADDR_W-1:0]  o_r_hdr_addr,
   output logic [NUM_CH*DATA_ADDR_W-1:0] o_r_data_addr,
`ifdef TL_RX_VC_CREDIT_RET_EN
   output logic [NUM_CH-1:0]             o_hdr_cred_ret,
   output logic [NUM_CH*INC_W-1:0]       o_data_cred_ret,
`endif
   output logic [NUM_CH-1:0]             o_hdr_empty,
   output logic [NUM_CH-1:0]             o_data_empty,
   output logic [NUM_CH-1:0]             o_hdr_full,
   output logic [NUM_CH-1:0]             o_data_full
);

   localparam int CH_W = $clog2(NUM_CH);

   logic [1:0]      state_q, state_d;
   logic [CH_W-1:0] ch_q, ch_mux;
   logic            w_ready, hdr_beat, data_beat, accept, chk_fire;
   logic            hdr_space, data_space;

   logic [NUM_CH-1:0][HDR_ADDR_W-1:0]  hdr_waddr;
   logic [NUM_CH-1:0][DATA_ADDR_W-1:0] data_waddr;
   logic [NUM_CH-1:0][HDR_ADDR_W:0]    hdr_free;
   logic [NUM_CH-1:0][DATA_ADDR_W:0]   data_free;
   logic [NUM_CH-1:0][INC_W-1:0]       hdr_pop, data_pop;
   logic [NUM_CH-1:0]                  data_ring_full;

   // IDLE looks at the incoming channel; afterwards the channel latched at sop is used
   assign ch_mux     = (state_q == ST_IDLE) ? i_w_ch : ch_q;
   assign hdr_space  = !o_hdr_full[ch_mux];
   assign data_space = data_free[ch_mux] >= (DATA_ADDR_W+1)'(i_w_data_cnt);

   always_comb begin
      w_ready = 1'b0;
      case (state_q)
         ST_IDLE: w_ready = hdr_space && data_space;
         ST_DATA: w_ready = data_space;
         default: w_ready = 1'b0;
      endcase
   end

   assign o_w_ready = w_ready && i_n_rst;
   assign hdr_beat  = o_w_ready && i_w_valid && i_w_sop && (state_q == ST_IDLE);
   assign data_beat = o_w_ready && i_w_valid && (state_q == ST_DATA);
   assign accept    = hdr_beat || data_beat;
   assign chk_fire  = i_chk_valid && (state_q == ST_CHK);

   assign o_w_hdr_en    = hdr_beat;
   assign o_w_data_en   = accept && (i_w_data_cnt != '0);
   assign o_w_ch_sel    = i_n_rst ? ch_mux : '0;
   assign o_w_hdr_addr  = hdr_waddr[ch_mux];
   assign o_w_data_addr = data_waddr[ch_mux];

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (hdr_beat) state_d = i_w_eop ? ST_CHK : ST_DATA;
         ST_DATA: if (data_beat && i_w_eop) state_d = ST_CHK;
         ST_CHK:  if (i_chk_valid) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         state_q <= ST_IDLE;
         ch_q    <= '0;
      end else begin
         state_q <= state_d;
         if (hdr_beat)
            ch_q <= i_w_ch;
      end
   end

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic sel_w, sel_c;
      assign sel_w = (ch_mux == CH_W'(c));
      assign sel_c = (ch_q == CH_W'(c));

      tl_rx_vc_ring_ptr #(.ADDR_W(HDR_ADDR_W), .INC_W(INC_W)) u_hdr (
         .clk     (i_clk),
         .n_rst   (i_n_rst),
         .wr_en   (hdr_beat && sel_w),
         .wr_cnt  (INC_W'(1)),
         .commit  (chk_fire && i_chk_ok && sel_c),
         .discard (chk_fire && !i_chk_ok && sel_c),
         .rd_en   (i_r_hdr_inc[c]),
         .rd_cnt  (INC_W'(1)),
         .wr_addr (hdr_waddr[c]),
         .rd_addr (o_r_hdr_addr[c*HDR_ADDR_W +: HDR_ADDR_W]),
         .empty   (o_hdr_empty[c]),
         .full    (o_hdr_full[c]),
         .free    (hdr_free[c]),
         .pop_cnt (hdr_pop[c])
      );

      tl_rx_vc_ring_ptr #(.ADDR_W(DATA_ADDR_W), .INC_W(INC_W)) u_data (
         .clk     (i_clk),
         .n_rst   (i_n_rst),
         .wr_en   (accept && sel_w),
         .wr_cnt  (i_w_data_cnt),
         .commit  (chk_fire && i_chk_ok && sel_c),
         .discard (chk_fire && !i_chk_ok && sel_c),
         .rd_en   (i_r_data_inc[c]),
         .rd_cnt  (i_r_data_cnt[c*INC_W +: INC_W]),
         .wr_addr (data_waddr[c]),
         .rd_addr (o_r_data_addr[c*DATA_ADDR_W +: DATA_ADDR_W]),
         .empty   (o_data_empty[c]),
         .full    (data_ring_full[c]),
         .free    (data_free[c]),
         .pop_cnt (data_pop[c])
      );

      // a whole max-size beat must fit, so full trips before the ring is truly full
      assign o_data_full[c] = data_free[c] < (DATA_ADDR_W+1)'(DATA_MAX_INC);
   end

`ifdef TL_RX_VC_CREDIT_RET_EN
   always_ff @(posedge i_clk or negedge i_n_rst) begin
      if (!i_n_rst) begin
         o_hdr_cred_ret  <= '0;
         o_data_cred_ret <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            o_hdr_cred_ret[c]                <= (hdr_pop[c] != '0);
            o_data_cred_ret[c*INC_W +: INC_W] <= data_pop[c];
         end
      end
   end

   logic unused_bits;
   assign unused_bits = ^{hdr_free, data_ring_full};
`else
   logic unused_bits;
   assign unused_bits = ^{hdr_free, data_ring_full, hdr_pop, data_pop};
`endif

endmodule

// File: tb/tb_tl_rx_vc_buffer_ctrl_mc.sv
// tb/tb_tl_rx_vc_buffer_ctrl_mc.sv - directed plus random bench with a counter-based queue model
module tb_tl_rx_vc_buffer_ctrl_mc;

   localparam int NUM_CH = 3;
   localparam int HA = 7;
   localparam int DA = 10;
   localparam int IW = 3;
   localparam int HD = 128;
   localparam int DD = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   logic w_valid, w_sop, w_eop, chk_valid, chk_ok;
   logic [1:0] w_ch;
   logic [IW-1:0] w_cnt;
   logic [NUM_CH-1:0] hpop, dpop;
   logic [IW-1:0] dcnt [NUM_CH];
   logic [NUM_CH*IW-1:0] r_data_cnt;
   assign r_data_cnt = {dcnt[2], dcnt[1], dcnt[0]};

   logic o_w_ready, o_w_hdr_en, o_w_data_en;
   logic [1:0] o_w_ch_sel;
   logic [HA-1:0] o_w_hdr_addr;
   logic [DA-1:0] o_w_data_addr;
   logic [NUM_CH*HA-1:0] o_r_hdr_addr;
   logic [NUM_CH*DA-1:0] o_r_data_addr;
   logic [NUM_CH-1:0] o_hdr_empty, o_data_empty, o_hdr_full, o_data_full;

   tl_rx_vc_buffer_ctrl_mc dut (
      .i_clk(clk), .i_n_rst(rst_n),
      .i_w_valid(w_valid), .o_w_ready(o_w_ready), .i_w_sop(w_sop), .i_w_eop(w_eop),
      .i_w_ch(w_ch), .i_w_data_cnt(w_cnt), .i_chk_valid(chk_valid), .i_chk_ok(chk_ok),
      .o_w_hdr_en(o_w_hdr_en), .o_w_data_en(o_w_data_en), .o_w_ch_sel(o_w_ch_sel),
      .o_w_hdr_addr(o_w_hdr_addr), .o_w_data_addr(o_w_data_addr),
      .i_r_hdr_inc(hpop), .i_r_data_inc(dpop), .i_r_data_cnt(r_data_cnt),
      .o_r_hdr_addr(o_r_hdr_addr), .o_r_data_addr(o_r_data_addr),
      .o_hdr_empty(o_hdr_empty), .o_data_empty(o_data_empty),
      .o_hdr_full(o_hdr_full), .o_data_full(o_data_full)
   );

   // model: unbounded entry counts per queue; addresses are counts modulo depth
   int hr [NUM_CH], hc [NUM_CH], hs [NUM_CH];
   int dr [NUM_CH], dc [NUM_CH], ds [NUM_CH];
   int phase;   // 0 waiting for sop, 1 inside TLP, 2 awaiting verdict
   int lat_ch;
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NUM_CH; c++) begin
         hr[c] = 0; hc[c] = 0; hs[c] = 0; dr[c] = 0; dc[c] = 0; ds[c] = 0;
      end
      phase = 0;
      lat_ch = 0;
   endtask

   task automatic set_w(input logic v, input logic s, input logic e, input int ch, input int cnt);
      w_valid = v; w_sop = s; w_eop = e; w_ch = 2'(ch); w_cnt = IW'(cnt);
   endtask

   task automatic clr_in();
      set_w(0, 0, 0, 0, 0);
      chk_valid = 0; chk_ok = 0; hpop = '0; dpop = '0;
      for (int c = 0; c < NUM_CH; c++) dcnt[c] = '0;
   endtask

   task automatic cycle();
      int ch, take;
      bit rdy, hb, db;
      #1;
      if (!rst_n) model_reset();
      ch  = (phase == 0) ? int'(w_ch) : lat_ch;
      rdy = rst_n && (phase != 2) && (phase != 0 || hs[ch] - hr[ch] < HD) &&
            (DD - (ds[ch] - dr[ch]) >= int'(w_cnt));
      hb  = rdy && w_valid && w_sop && phase == 0;
      db  = rdy && w_valid && phase == 1;
      if (w_valid || phase == 2) check("w_ready", o_w_ready, rdy);
      check("hdr_en", o_w_hdr_en, hb);
      check("data_en", o_w_data_en, (hb || db) && w_cnt != 0);
      if (hb || db) begin
         check("ch_sel", o_w_ch_sel, ch);
         check("w_hdr_addr", o_w_hdr_addr, hs[ch] % HD);
         check("w_data_addr", o_w_data_addr, ds[ch] % DD);
      end
      for (int c = 0; c < NUM_CH; c++) begin
         check("hdr_empty", o_hdr_empty[c], hc[c] == hr[c]);
         check("data_empty", o_data_empty[c], dc[c] == dr[c]);
         check("hdr_full", o_hdr_full[c], hs[c] - hr[c] == HD);
         check("data_full", o_data_full[c], DD - (ds[c] - dr[c]) < 4);
         check("r_hdr_addr", o_r_hdr_addr[c*HA +: HA], hr[c] % HD);
         check("r_data_addr", o_r_data_addr[c*DA +: DA], dr[c] % DD);
      end
      @(posedge clk);
      if (rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (hpop[c] && hc[c] > hr[c]) hr[c]++;
            if (dpop[c]) begin
               take = int'(dcnt[c]);
               if (take > dc[c] - dr[c]) take = dc[c] - dr[c];
               dr[c] += take;
            end
         end
         if (hb) begin
            lat_ch = ch; hs[ch]++; ds[ch] += int'(w_cnt);
            phase = w_eop ? 2 : 1;
         end else if (db) begin
            ds[ch] += int'(w_cnt);
            if (w_eop) phase = 2;
         end else if (phase == 2 && chk_valid) begin
            if (chk_ok) begin hc[lat_ch] = hs[lat_ch]; dc[lat_ch] = ds[lat_ch]; end
            else        begin hs[lat_ch] = hc[lat_ch]; ds[lat_ch] = dc[lat_ch]; end
            phase = 0;
         end
      end
      @(negedge clk);
   endtask

   task automatic verdict(input logic ok);
      set_w(0, 0, 0, 0, 0);
      chk_valid = 1; chk_ok = ok;
      cycle();
      chk_valid = 0;
   endtask

   initial begin
      clr_in();
      rst_n = 0;
      model_reset();
      @(negedge clk);
      set_w(1, 1, 1, 0, 2);
      #1;
      check("rst_ready", o_w_ready, 0);
      check("rst_hdr_en", o_w_hdr_en, 0);
      check("rst_hdr_empty", o_hdr_empty, 3'b111);
      check("rst_data_full", o_data_full, 3'b000);
      cycle();
      cycle();
      rst_n = 1;
      clr_in();
      cycle();

      // single-beat TLP to ch0, committed
      set_w(1, 1, 1, 0, 2);
      #1;
      check("t1_hdr_en", o_w_hdr_en, 1);
      check("t1_data_en", o_w_data_en, 1);
      check("t1_hdr_addr", o_w_hdr_addr, 0);
      check("t1_data_addr", o_w_data_addr, 0);
      cycle();
      check("t1_chk_ready", o_w_ready, 0);
      verdict(1);
      check("t1_hdr_empty", o_hdr_empty[0], 0);
      check("t1_rd_data", o_r_data_addr[DA-1:0], 0);

      // three-beat TLP to ch1, discarded, then a new TLP reuses the same addresses
      set_w(1, 1, 0, 1, 4); cycle();
      set_w(1, 0, 0, 1, 4); cycle();
      set_w(1, 0, 1, 1, 4); cycle();
      verdict(0);
      check("t2_hdr_empty", o_hdr_empty[1], 1);
      check("t2_data_empty", o_data_empty[1], 1);
      set_w(1, 1, 1, 1, 2);
      #1;
      check("t2_reuse_data", o_w_data_addr, 0);
      check("t2_reuse_hdr", o_w_hdr_addr, 0);
      cycle();
      verdict(0);

      // fill the ch2 header ring
      for (int i = 0; i < HD; i++) begin
         set_w(1, 1, 1, 2, 0); cycle();
         verdict(1);
      end
      check("t3_hdr_full", o_hdr_full[2], 1);
      set_w(1, 1, 1, 2, 1);
      #1;
      check("t3_ch2_blocked", o_w_ready, 0);
      cycle();
      set_w(1, 1, 1, 0, 1);
      #1;
      check("t3_ch0_ok", o_w_ready, 1);
      cycle();
      verdict(1);

      // data wrap on ch1: 1022 entries in, 1020 out, then a 4-entry beat wraps
      set_w(1, 1, 0, 1, 2); cycle();
      for (int i = 0; i < 254; i++) begin
         set_w(1, 0, 0, 1, 4); cycle();
      end
      set_w(1, 0, 1, 1, 4); cycle();
      verdict(1);
      check("t4_data_full", o_data_full[1], 1);
      for (int i = 0; i < 255; i++) begin
         dpop[1] = 1; dcnt[1] = 4; cycle();
      end
      clr_in();
      check("t4_rd_1020", o_r_data_addr[DA +: DA], 1020);
      set_w(1, 1, 1, 1, 4);
      #1;
      check("t4_wr_1022", o_w_data_addr, 1022);
      cycle();
      check("t4_wrapped", o_w_data_addr, 2);
      verdict(1);
      check("t4_not_empty", o_data_empty[1], 0);

      // commit and pop on ch0 in the same cycle
      set_w(1, 1, 1, 0, 4); cycle();
      set_w(0, 0, 0, 0, 0);
      chk_valid = 1; chk_ok = 1; dpop[0] = 1; dcnt[0] = 3; hpop[0] = 1;
      cycle();
      clr_in();
      check("t5_rd_data", o_r_data_addr[DA-1:0], 3);
      check("t5_not_empty", o_data_empty[0], 0);
      dpop[0] = 1; dcnt[0] = 4; cycle();
      clr_in();
      check("t5_drained", o_data_empty[0], 1);

      // reset while inside a TLP
      set_w(1, 1, 0, 1, 3); cycle();
      set_w(1, 0, 0, 1, 2);
      rst_n = 0;
      #1;
      check("t6_data_en", o_w_data_en, 0);
      check("t6_ready", o_w_ready, 0);
      check("t6_hdr_empty", o_hdr_empty, 3'b111);
      check("t6_data_empty", o_data_empty, 3'b111);
      cycle();
      rst_n = 1;
      clr_in();
      cycle();
      check("t6_rd_addr", o_r_data_addr, 0);
      check("t6_hdr_full", o_hdr_full, 0);

      // random traffic
      for (int i = 0; i < 1500; i++) begin
         hpop = NUM_CH'($urandom_range(0, 7));
         dpop = NUM_CH'($urandom_range(0, 7));
         for (int c = 0; c < NUM_CH; c++) dcnt[c] = IW'($urandom_range(0, 4));
         chk_valid = 1'($urandom_range(0, 1));
         chk_ok = 1'($urandom_range(0, 1));
         if (phase == 0)
            set_w(1'($urandom_range(0, 1)), 1, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 2), $urandom_range(0, 4));
         else if (phase == 1)
            set_w(1'($urandom_range(0, 1)), 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2), $urandom_range(0, 4));
         else
            set_w(0, 0, 0, 0, 0);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tl_rx_vc_buffer_ctrl_mc.md
Name: tl_rx_vc_buffer_ctrl_mc

Overview:
Multi-channel successor to the RX VC buffer controller; it owns the header and data ring pointers for NUM_CH receive queues (posted, non-posted, completion by default). Pointers are registered, and data writes advance by a variable entry count per beat. Writes are speculative until the TLP passes error check; a good TLP is committed and a bad one is discarded with a pointer rollback. The block sits between the RX TLP write path / error checker and the per-channel header and data RAMs feeding the RX arbiter.

Parameters:
NUM_CH, 3, number of receive queues
HDR_ADDR_W, 7, header RAM address width; depth 2**HDR_ADDR_W entries per channel
DATA_ADDR_W, 10, data RAM address width; depth 2**DATA_ADDR_W entries per channel
DATA_MAX_INC, 4, maximum data entries per write or read beat
INC_W, 3, width of increment fields; must hold DATA_MAX_INC

Ports:
i_clk  in  1  clock
i_n_rst  in  1  asynchronous active-low reset
i_w_valid  in  1  write beat valid
o_w_ready  out  1  write beat accepted when high with i_w_valid
i_w_sop  in  1  beat carries the header (first beat of TLP)
i_w_eop  in  1  last beat of TLP
i_w_ch  in  $clog2(NUM_CH)  target queue, sampled on the sop beat
i_w_data_cnt  in  INC_W  data entries in this beat, 0..DATA_MAX_INC
i_chk_valid  in  1  error-check verdict valid
i_chk_ok  in  1  1 = commit, 0 = discard
o_w_hdr_en  out  1  header RAM write strobe
o_w_data_en  out  1  data RAM write strobe
o_w_ch_sel  out  $clog2(NUM_CH)  queue being written
o_w_hdr_addr  out  HDR_ADDR_W  header write address
o_w_data_addr  out  DATA_ADDR_W  data write base address
i_r_hdr_inc  in  NUM_CH  per-channel header pop
i_r_data_inc  in  NUM_CH  per-channel data pop
i_r_data_cnt  in  NUM_CH*INC_W  per-channel data entries popped
o_r_hdr_addr  out  NUM_CH*HDR_ADDR_W  per-channel header read address
o_r_data_addr  out  NUM_CH*DATA_ADDR_W  per-channel data read address
o_hdr_empty  out  NUM_CH  no committed header
o_data_empty  out  NUM_CH  no committed data
o_hdr_full  out  NUM_CH  header ring full (speculative)
o_data_full  out  NUM_CH  fewer than DATA_MAX_INC free data entries (speculative)

Behaviour:
- Pointers: per channel, read pointer, committed write pointer and speculative write pointer; each is address width + 1 (wrap bit). All reset to 0.
- Addresses are pointer[addr_w-1:0]. Additions are modulo 2**(addr_w+1), so the wrap bit toggles naturally.
- Empty: read pointer == committed write pointer.
- Header full: speculative write pointer and read pointer have differing MSBs and equal lower bits.
- Data free count = depth - (speculative write pointer - read pointer).
- FSM states: IDLE=2'b00, HDR=2'b01, DATA=2'b10, CHK=2'b11. Reset to IDLE.
  - IDLE: waits for i_w_valid & i_w_sop; this cycle is the HDR beat.
  - HDR beat: o_w_hdr_en=1 and o_w_data_en=(i_w_data_cnt!=0), combinational in the accept cycle. Channel is latched. Speculative header pointer +1, speculative data pointer +i_w_data_cnt. Next state is CHK if i_w_eop, else DATA.
  - DATA: each accepted beat asserts o_w_data_en when cnt!=0 and advances the speculative data pointer. i_w_eop moves to CHK.
  - CHK: o_w_ready=0. On i_chk_valid: if i_chk_ok, committed pointers := speculative pointers; otherwise speculative pointers := committed pointers. Return to IDLE next cycle.
- o_w_ready=1 in IDLE/HDR/DATA only if the addressed channel has header space (sop beat) and data free count >= i_w_data_cnt. When o_w_ready=0, no strobes are driven and no pointer moves.
- Read pops: a header pop while o_hdr_empty is ignored. A data pop advances by min(i_r_data_cnt, committed occupancy). Pops on all channels are independent and may coincide with a commit or discard on the same channel; both take effect in that cycle.
- Flags are combinational from registers. Write address outputs show speculative pointers of the latched channel, or of i_w_ch in IDLE.
- Reset mid-TLP: all pointers return to 0 and state to IDLE. Any in-flight TLP is lost; no strobes are driven during reset.
- Reset values: all strobes 0, all addresses 0, o_w_ready 0 during reset, empty flags 1, full flags 0.

Optional Feature:
TL_RX_VC_CREDIT_RET_EN:
- Defined: adds outputs o_hdr_cred_ret (NUM_CH) and o_data_cred_ret (NUM_CH*INC_W), registered one cycle after each effective pop. They carry 1 and the actual popped count for the flow-control credit update block.
- Undefined: these ports do not exist; behaviour is otherwise identical.

Decomposition:
- Package tl_rx_vc_pkg: FSM state encodings, channel index constants (P=0, NP=1, CPL=2), and pointer-width helper localparams.
- One natural sub-module, tl_rx_vc_ring_ptr: parametrised read / committed / speculative pointer triplet with flags. It is instantiated 2*NUM_CH times.

Test Plan:
- Reset, then 1-beat TLP to ch0 (sop, eop, cnt=2), chk_ok -> hdr_addr 0 written, data_addr 0; ch0 hdr_empty drops one cycle after commit; data read pointer 0.
- TLP to ch1 with 3 beats of cnt=4, chk_ok=0 -> strobes issued, then speculative pointers roll back to 0; ch1 empty stays 1; next TLP reuses data_addr 0.
- Fill ch2 header ring with 128 committed TLPs -> o_hdr_full[2]=1, o_w_ready=0 for sop to ch2 while ch0 is still accepted.
- Data wrap: fill to 1022 entries, pop 1020, write cnt=4 -> data_addr wraps 1022→2 and the MSB toggles; occupancy is correct.
- Commit on ch0 in the same cycle as a ch0 pop of cnt=3 -> both apply; empty and occupancy are consistent with the sum.
- Assert reset in DATA state -> state IDLE, all pointers 0, no strobes, all empties 1.
